// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with 16x oversampling and 3-sample majority vote per bit.
module uart_rx_byte #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  input  logic [2:0] baud_set,
  output logic [7:0] byte_out,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;
  localparam logic [13:0] D0 = 14'(CLK_FREQ / 4800);
  localparam logic [13:0] D1 = 14'(CLK_FREQ / 19200);
  localparam logic [13:0] D2 = 14'(CLK_FREQ / 38400);
  localparam logic [13:0] D3 = 14'(CLK_FREQ / 76800);
  localparam logic [13:0] D4 = 14'(CLK_FREQ / 153600);
  localparam logic [13:0] D5 = 14'(CLK_FREQ / 307200);
  localparam logic [13:0] D6 = 14'(CLK_FREQ / 1843200);
  logic        s1, s2, s3;
  logic [2:0]  state, baud, bit_idx;
  logic [13:0] tick_cnt, div;
  logic [3:0]  tick_idx;
  logic [7:0]  shift;
  logic [1:0]  smp;
  logic        tick, maj, mid, last;
  always_comb begin
    div  = baud == 3'd0 ? D0 : baud == 3'd1 ? D1 : baud == 3'd2 ? D2 : baud == 3'd3 ? D3 :
           baud == 3'd4 ? D4 : baud == 3'd5 ? D5 : D6;
    tick = tick_cnt == div - 14'd1;
    maj  = (smp[0] & smp[1]) | (smp[0] & s2) | (smp[1] & s2);
    mid  = tick && tick_idx == 4'd9;
    last = tick && tick_idx == 4'd15;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {s3, s2, s1} <= 3'b111;
      state     <= IDLE;
      baud      <= 3'd0;
      bit_idx   <= 3'd0;
      tick_cnt  <= 14'd0;
      tick_idx  <= 4'd0;
      shift     <= 8'd0;
      smp       <= 2'd0;
      byte_out  <= 8'd0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      {s3, s2, s1} <= {s2, s1, uart_rx};
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      tick_cnt  <= (state == IDLE || tick) ? 14'd0 : tick_cnt + 14'd1;
      tick_idx  <= state == IDLE ? 4'd0 : tick ? tick_idx + 4'd1 : tick_idx;
      if (tick && tick_idx == 4'd7) smp[0] <= s2;
      if (tick && tick_idx == 4'd8) smp[1] <= s2;
      case (state)
        IDLE: if (s3 && !s2) begin
          state   <= START;
          baud    <= baud_set;
          bit_idx <= 3'd0;
        end
        START: if (mid && maj) state <= IDLE;
          else if (last) begin
            state   <= DATA;
            bit_idx <= 3'd0;
          end
        DATA: begin
          if (mid) shift[bit_idx] <= maj;
          if (last) begin
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end
        end
        // Leave at mid-stop so a zero-gap following start edge is still seen in IDLE.
        STOP: if (mid) begin
          if (maj) begin
            byte_out <= shift;
            rx_done  <= 1'b1;
            state    <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= BRK;
          end
        end
        BRK: if (s2) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed serial frames with a byte scoreboard checked on each rx_done.
module tb_uart_rx_byte;
  localparam int CLK = 1_843_200;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic [2:0] baud_set = 3'd6;
  logic [7:0] byte_out;
  logic       rx_done, frame_err, busy;
  int compared = 0, mismatched = 0, fe_cnt = 0, cyc = 0;
  int done_cyc = 0, prev_done_cyc = 0, start_cyc = 0, b = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  uart_rx_byte #(.CLK_FREQ(CLK)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .baud_set(baud_set),
    .byte_out(byte_out), .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      compared++;
      assert (exp_q.size() > 0) else begin
        mismatched++;
        $error("FAIL unexpected_rx_done: observed byte_out=%h, expected no pulse", byte_out);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compared++;
        assert (byte_out === e) else begin
          mismatched++;
          $error("FAIL rx_byte: observed %h expected %h", byte_out, e);
        end
      end
      prev_done_cyc = done_cyc;
      done_cyc = cyc;
    end
    if (frame_err) fe_cnt++;
    if (rx_done || frame_err) begin
      compared++;
      assert ((rx_done & frame_err) === 1'b0) else begin
        mismatched++;
        $error("FAIL pulse_overlap: observed rx_done=%b frame_err=%b expected not both", rx_done, frame_err);
      end
    end
  end

  function automatic int bclk(input logic [2:0] bs);
    int baud;
    baud = bs == 3'd0 ? 300 : bs == 3'd1 ? 1200 : bs == 3'd2 ? 2400 : bs == 3'd3 ? 4800 :
           bs == 3'd4 ? 9600 : bs == 3'd5 ? 19200 : 115200;
    return 16 * (CLK / (baud * 16));
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_rng(input string tag, input int got, input int lo, input int hi);
    compared++;
    assert (got >= lo && got <= hi) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bt, input logic [2:0] nb);
    start_cyc = cyc;
    uart_rx = 1'b0;
    clks(bt);
    baud_set = nb;
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      clks(bt);
    end
    uart_rx = stop;
    clks(bt);
  endtask

  initial begin
    clks(4);
    check("reset_byte_out", byte_out, 0);
    check("reset_rx_done", rx_done, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    clks(4);
    // single frame at the fastest rate, with latency
    baud_set = 3'd6;
    b = bclk(3'd6);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, b, 3'd6);
    clks(2 * b);
    check_rng("t1_latency", done_cyc - start_cyc, 156, 158);
    check("t1_byte_out", byte_out, 8'h55);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_busy_idle", busy, 0);
    // back-to-back frames at 9600
    baud_set = 3'd4;
    b = bclk(3'd4);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_frame(8'hA5, 1'b1, b, 3'd4);
    send_frame(8'h3C, 1'b1, b, 3'd4);
    clks(b);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_byte_out", byte_out, 8'h3C);
    check_rng("t2_spacing", done_cyc - prev_done_cyc, 10 * b - 2, 10 * b + 2);
    // start glitch
    baud_set = 3'd6;
    b = bclk(3'd6);
    uart_rx = 1'b0;
    clks(6);
    check("t3_busy_in_start", busy, 1);
    uart_rx = 1'b1;
    clks(3 * b);
    check("t3_busy_idle", busy, 0);
    check("t3_no_frame_err", fe_cnt, 0);
    check("t3_byte_out_held", byte_out, 8'h3C);
    // framing error then held break
    send_frame(8'h81, 1'b0, b, 3'd6);
    clks(30 * b);
    uart_rx = 1'b1;
    clks(2 * b);
    check("t4_one_frame_err", fe_cnt, 1);
    check("t4_byte_out_held", byte_out, 8'h3C);
    check("t4_busy_idle", busy, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, b, 3'd6);
    clks(2 * b);
    check("t4_recover_byte", byte_out, 8'h7E);
    check("t4_queue_empty", exp_q.size(), 0);
    // reset during data bit 4 of 0xF0
    uart_rx = 1'b0;
    clks(5 * b);
    uart_rx = 1'b1;
    clks(b / 2);
    check("t5_busy_mid", busy, 1);
    rst = 1'b1;
    clks(2);
    check("t5_busy_reset", busy, 0);
    check("t5_byte_out_reset", byte_out, 0);
    rst = 1'b0;
    clks(3 * b);
    check("t5_busy_after", busy, 0);
    check("t5_no_frame_err", fe_cnt, 1);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, b, 3'd6);
    clks(2 * b);
    check("t5_byte_out", byte_out, 8'h0F);
    check("t5_queue_empty", exp_q.size(), 0);
    // all byte values back-to-back at 115200
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, b, 3'd6);
    end
    clks(2 * b);
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_no_frame_err", fe_cnt, 1);
    check("t6_last_byte", byte_out, 8'hFF);
    // 1200 baud, with baud_set changed mid-frame (must be ignored)
    baud_set = 3'd1;
    b = bclk(3'd1);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, b, 3'd6);
    clks(b);
    check("t7_byte_out", byte_out, 8'hC3);
    check("t7_queue_empty", exp_q.size(), 0);
    check("t7_no_frame_err", fe_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
